// File: rtl/gcd_host.sv
// gcd_host: request-side sequencer for a subtractive GCD core.
//
// Accepts an operand pair on a valid/ready request port. Pairs with a zero
// operand are answered directly as a|b. For other pairs the block resets the
// core, presents A with a start strobe and then B, and waits for done. The
// wait is bounded by TIMEOUT cycles. The result (or a timeout abort) is
// returned on a valid/ready response port.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset
//   req_valid_i    request present
//   req_ready_o    block can accept a request (IDLE only)
//   req_a_i/b_i    operands
//   rsp_valid_o    response present
//   rsp_ready_i    master accepts the response
//   rsp_gcd_o      result, 0 on timeout
//   rsp_timeout_o  response is a timeout abort
//   core_rst_o     reset to the core (rst_i or CLR state)
//   core_start_o   start strobe to the core, high while A is on the bus
//   core_data_o    core operand bus
//   core_done_i    core finished
//   core_result_i  core result, valid while core_done_i
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a request; zero-operand pairs go straight to RESP
// CLR     | core_rst pulse, one cycle
// SEND_A  | core_start=1, core_data=A
// SEND_B  | core_start=0, core_data=B
// WAIT    | waiting for core_done, bounded by TIMEOUT cycles
// RESP    | rsp_valid=1 until the master takes the response
//
// The zero-operand bypass is resolved at accept time. This lets its
// response appear in the cycle right after the accept.

module gcd_host #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_gcd_o,
    output logic             rsp_timeout_o,
    output logic             core_rst_o,
    output logic             core_start_o,
    output logic [WIDTH-1:0] core_data_o,
    input  logic             core_done_i,
    input  logic [WIDTH-1:0] core_result_i
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SEND_A,
        S_SEND_B,
        S_WAIT,
        S_RESP
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_gcd_q;
    logic             rsp_timeout_q;
    logic             core_start_q;
    logic [WIDTH-1:0] core_data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            op_a_q        <= '0;
            op_b_q        <= '0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_gcd_q     <= '0;
            rsp_timeout_q <= 1'b0;
            core_start_q  <= 1'b0;
            core_data_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        op_a_q <= req_a_i;
                        op_b_q <= req_b_i;
                        // The core hangs on a zero operand, so answer a|b here.
                        if (req_a_i == '0 || req_b_i == '0) begin
                            rsp_gcd_q     <= req_a_i | req_b_i;
                            rsp_timeout_q <= 1'b0;
                            rsp_valid_q   <= 1'b1;
                            state_q       <= S_RESP;
                        end else begin
                            state_q <= S_CLR;
                        end
                    end
                end
                S_CLR: begin
                    core_start_q <= 1'b1;
                    core_data_q  <= op_a_q;
                    state_q      <= S_SEND_A;
                end
                S_SEND_A: begin
                    core_start_q <= 1'b0;
                    core_data_q  <= op_b_q;
                    state_q      <= S_SEND_B;
                end
                S_SEND_B: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // done has priority over an expiring timeout
                    if (core_done_i) begin
                        rsp_gcd_q     <= core_result_i;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        core_data_q   <= '0;
                        state_q       <= S_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        rsp_gcd_q     <= '0;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        core_data_q   <= '0;
                        state_q       <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Reset gates these decodes, so both show their reset values while rst_i is high.
    assign req_ready_o   = (state_q == S_IDLE) && !rst_i;
    assign core_rst_o    = rst_i || (state_q == S_CLR);

    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_gcd_o     = rsp_gcd_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign core_start_o  = core_start_q;
    assign core_data_o   = core_data_q;

endmodule

// File: tb/tb_gcd_host.sv
module tb_gcd_host;

    localparam int W = 16;
    localparam int T = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_gcd;
    logic         rsp_timeout;
    logic         core_rst;
    logic         core_start;
    logic [W-1:0] core_data;
    logic         core_done;
    logic [W-1:0] core_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gcd_host #(.WIDTH(W), .TIMEOUT(T)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_a_i       (req_a),
        .req_b_i       (req_b),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_gcd_o     (rsp_gcd),
        .rsp_timeout_o (rsp_timeout),
        .core_rst_o    (core_rst),
        .core_start_o  (core_start),
        .core_data_o   (core_data),
        .core_done_i   (core_done),
        .core_result_i (core_result)
    );

    // Behavioural GCD core. It captures A with start and B on the following
    // cycle. After cm_lat further cycles it raises done and holds it until
    // its next reset.
    logic [W-1:0] cm_a = '0;
    logic [W-1:0] cm_res = '0;
    logic         cm_phase = 1'b0;
    logic         cm_busy = 1'b0;
    int           cm_cnt = 0;
    int           cm_lat = 0;
    logic         cm_never = 1'b0;
    logic         force_done = 1'b0;
    logic [W-1:0] force_res = '0;

    function automatic logic [W-1:0] sub_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
        if (x == 0) return y;
        if (y == 0) return x;
        while (x != y) begin
            if (x > y) x = x - y;
            else       y = y - x;
        end
        return x;
    endfunction

    always @(posedge clk) begin
        if (core_rst) begin
            cm_busy  <= 1'b0;
            cm_phase <= 1'b0;
        end else if (core_start) begin
            cm_a     <= core_data;
            cm_phase <= 1'b1;
        end else if (cm_phase) begin
            cm_res   <= sub_gcd(cm_a, core_data);
            cm_cnt   <= cm_lat;
            cm_busy  <= 1'b1;
            cm_phase <= 1'b0;
        end else if (cm_busy && cm_cnt != 0) begin
            cm_cnt <= cm_cnt - 1;
        end
    end

    assign core_done   = (cm_busy && cm_cnt == 0 && !cm_never) || force_done;
    assign core_result = force_done ? force_res : (core_done ? cm_res : 16'hDEAD);

    // Reference: Euclid by remainder, gcd(x,0)=x
    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // One full transaction. Call at a negedge while the DUT is idle.
    task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int lat, input bit never, input int hold);
        logic [W-1:0] exp_g;
        bit           exp_to;
        bit           zero;
        int           k;
        zero   = (a == 0) || (b == 0);
        exp_to = !zero && never;
        exp_g  = exp_to ? '0 : ref_gcd(a, b);
        cm_lat   = lat;
        cm_never = never;

        chk("idle_ready", req_ready, 1);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        step();                                 // cycle N+1
        req_valid = 1'b0;
        req_a     = W'($urandom);
        req_b     = W'($urandom);
        chk("busy_ready", req_ready, 0);
        if (zero) begin
            chk("byp_valid", rsp_valid, 1);
            chk("byp_start", core_start, 0);
            chk("byp_core_rst", core_rst, 0);
        end else begin
            chk("clr_core_rst", core_rst, 1);
            chk("clr_valid", rsp_valid, 0);
            chk("clr_data", core_data, 0);
            step();                             // N+2
            chk("a_start", core_start, 1);
            chk("a_data", core_data, a);
            chk("a_core_rst", core_rst, 0);
            step();                             // N+3
            chk("b_start", core_start, 0);
            chk("b_data", core_data, b);
            step();                             // N+4, first WAIT cycle
            chk("wait_data", core_data, b);
            k = 0;
            while (!rsp_valid && k < T + 8) begin
                step();
                k++;
            end
            chk("rsp_latency", k, never ? T : lat + 1);
        end
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_gcd", rsp_gcd, exp_g);
        chk("rsp_timeout", rsp_timeout, exp_to);
        chk("rsp_data", core_data, 0);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_valid", rsp_valid, 1);
            chk("hold_gcd", rsp_gcd, exp_g);
            chk("hold_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("post_valid", rsp_valid, 0);
        chk("post_ready", req_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        logic [W-1:0] ra, rb;

        // Reset values
        step();
        step();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_gcd", rsp_gcd, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_data", core_data, 0);
        chk("rst_core_rst", core_rst, 1);
        rst = 1'b0;
        #1;
        chk("first_ready", req_ready, 1);
        step();

        // Normal operation and zero-operand bypass
        do_req(16'd48, 16'd18, 3, 1'b0, 0);
        do_req(16'd0, 16'd35, 0, 1'b0, 0);
        do_req(16'd35, 16'd0, 0, 1'b0, 0);
        do_req(16'd0, 16'd0, 0, 1'b0, 0);

        // Timeout, then recovery through CLR
        do_req(16'd9, 16'd6, 0, 1'b1, 0);
        do_req(16'd12, 16'd8, 2, 1'b0, 0);

        // Backpressure
        do_req(16'd100, 16'd75, 4, 1'b0, 5);

        // Reset during WAIT
        cm_lat   = 10;
        cm_never = 1'b0;
        req_valid = 1'b1;
        req_a = 16'd1071;
        req_b = 16'd462;
        step();
        req_valid = 1'b0;
        repeat (4) step();                      // in WAIT
        rst = 1'b1;
        #1;
        chk("mid_rst_core_rst", core_rst, 1);
        chk("mid_rst_ready", req_ready, 0);
        step();
        rst = 1'b0;
        #1;
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_rsp_gcd", rsp_gcd, 0);
        chk("mid_rsp_timeout", rsp_timeout, 0);
        chk("mid_core_start", core_start, 0);
        chk("mid_core_data", core_data, 0);
        chk("mid_ready", req_ready, 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rsp_valid) seen++;
        end
        chk("mid_no_rsp", seen, 0);
        do_req(16'd21, 16'd14, 5, 1'b0, 1);

        // done and timeout expiring in the same cycle
        do_req(16'd27, 16'd18, T - 1, 1'b0, 0);

        // done while idle is ignored
        force_res  = 16'd9;
        force_done = 1'b1;
        step();
        step();
        chk("idle_done_valid", rsp_valid, 0);
        chk("idle_done_ready", req_ready, 1);
        force_done = 1'b0;
        step();

        // Randomized transactions
        for (int n = 0; n < 25; n++) begin
            ra = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 4095));
            rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 4095));
            do_req(ra, rb, $urandom_range(0, T - 1), ($urandom_range(0, 7) == 0),
                   $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcd_host.md
# gcd_host

Request-side sequencer for the subtractive GCD core. It accepts an operand pair over a valid/ready request port and drives the core's start, operand bus and reset in the required order. It then waits for the core's done, bounded by a timeout, and returns the result over a valid/ready response port. It sits between a system master and one GCD core instance and shields the master from the core's operand timing and its zero-operand hang.

## Interface
- WIDTH, 16, operand/result width
- TIMEOUT, 1024, max WAIT cycles before abort (≥2)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept request
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- rsp_valid  out  1  response present
- rsp_ready  in  1  master accepts response
- rsp_gcd  out  WIDTH  result (0 on timeout)
- rsp_timeout  out  1  response is a timeout abort
- core_rst  out  1  reset pulse to GCD core
- core_start  out  1  start strobe to core
- core_data  out  WIDTH  core operand bus
- core_done  in  1  core finished
- core_result  in  WIDTH  core A register (valid while core_done)

## Operation
- Request is accepted on a cycle where req_valid && req_ready. req_a/req_b are latched into opA/opB.
- States and transitions:
  - IDLE: req_ready=1. On accept, go to BYPASS if opA==0 or opB==0, else go to CLR.
  - BYPASS: result = opA|opB, so gcd(0,b)=b, gcd(a,0)=a and gcd(0,0)=0. Load response and go to RESP. The core is never started for a zero operand.
  - CLR: core_rst=1 for exactly one cycle, then go to SEND_A.
  - SEND_A: core_start=1 and core_data=opA, then go to SEND_B.
  - SEND_B: core_start=0 and core_data=opB, then go to WAIT with the counter cleared.
  - WAIT: core_data=opB.
    - If core_done, capture core_result into rsp_gcd, set rsp_timeout=0 and go to RESP.
    - Else if cnt==TIMEOUT-1, set rsp_gcd=0, rsp_timeout=1 and go to RESP.
    - Else increment cnt.
  - RESP: rsp_valid=1, with rsp_gcd and rsp_timeout stable. When rsp_ready, go to IDLE.
- If core_done and the timeout condition occur in the same cycle, done wins.
- core_done outside WAIT is ignored.
- cnt is ceil(log2(TIMEOUT)) bits wide and never wraps, because WAIT exits at TIMEOUT-1.
- The core is assumed unreliable after a timeout. The next request always passes through CLR.
- core_data is 0 in IDLE, CLR, BYPASS and RESP.

## Timing
- All outputs are registered or decoded from the state register. No combinational path from req_* or rsp_ready to any output.
- Reset values, held while rst=1:
  - req_ready=0
  - rsp_valid=0
  - rsp_gcd=0
  - rsp_timeout=0
  - core_start=0
  - core_data=0
  - core_rst=1 (core_rst = rst | state==CLR)
- State after reset is IDLE, so req_ready=1 in the first cycle with rst=0.
- Reset mid-operation, in any state: the next state is IDLE. An in-flight request is dropped with no response, and an unaccepted response is discarded.
- Zero-operand latency: accept in cycle N, rsp_valid in cycle N+1.
- Normal path timing:
  - Accept in cycle N.
  - core_rst in N+1.
  - core_start with A in N+2.
  - B in N+3.
  - WAIT from N+4.
  - core_done sampled in cycle M gives rsp_valid in M+1.
- Timeout: with no done, rsp_valid rises exactly TIMEOUT cycles after entering WAIT.
- Backpressure: rsp_valid stays high and rsp_* are held for as long as rsp_ready=0. req_ready=0 throughout, so there is one outstanding request maximum.
- Back-to-back: response handshake in cycle K puts the block in IDLE in K+1, so the next accept is earliest in K+1.

## Test plan
- Real GCD core attached, req (48,18): core_rst at N+1, start with data 48 at N+2, data 18 at N+3 -> rsp_gcd=6 and rsp_timeout=0, rsp_valid one cycle after core_done.
- req (0,35), then (35,0), then (0,0): core_start stays 0 -> rsp_gcd 35, 35, 0, each with rsp_valid at N+1.
- Stub core with done tied 0, TIMEOUT=8: rsp_valid exactly 8 cycles after entering WAIT with rsp_timeout=1 and rsp_gcd=0. The next req (12,8) passes through CLR -> rsp_gcd=4.
- req (100,75) with rsp_ready held 0 for 5 cycles after rsp_valid: rsp_gcd=25 is stable the whole time, req_ready=0 throughout, handshake on cycle 6, then IDLE.
- rst asserted for 1 cycle during WAIT of req (1071,462): next cycle in IDLE with all outputs at reset values and no response. A new req (21,14) -> rsp_gcd=7.
- Stub core asserts done and the timeout condition in the same cycle with core_result=9 -> rsp_gcd=9 and rsp_timeout=0. core_done pulsed in IDLE -> no effect.
